// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: mid-bit sampling from the detected start edge, one byte
// held on a valid/ready port with one-cycle frame-error and overrun pulses.
module uart_rx_frame #(
  parameter int SYSTEM_CLOCK_FREQ = 100000000,
  parameter int BAUD_RATE         = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int          DIVIDER   = SYSTEM_CLOCK_FREQ / BAUD_RATE;
  localparam int          HALF      = DIVIDER / 2;
  localparam logic [15:0] DIV_LAST  = 16'(DIVIDER - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t      state_q;
  logic        sync1_q;
  logic        rx_s_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  shift_d;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        frame_err_q;
  logic        overrun_q;

  always_comb begin
    cnt_d   = cnt_q + 16'd1;
    // LSB arrives first, so shifting right leaves bit 0 in shift_q[0]
    shift_d = {rx_s_q, shift_q[7:1]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= rx;
      rx_s_q      <= sync1_q;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (valid_q && ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) begin
            state_q <= S_START;
          end
        end

        S_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            // a line back high at mid-start was only a glitch
            state_q   <= rx_s_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_DATA: begin
          if (cnt_q == DIV_LAST) begin
            shift_q   <= shift_d;
            cnt_q     <= '0;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_STOP: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= S_IDLE;
              // a same-cycle accept frees the holding register for the new byte
              if (!valid_q || ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_WAIT_HIGH: begin
          cnt_q <= '0;
          if (rx_s_q) begin
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Serial UART receiver: recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from the asynchronous `rx` line and presents each byte on a valid/ready output port. It has its own bit-rate divider with the same clock/baud parameters as the transmit-side baud generator. It samples each bit at mid-bit, measured from the detected start edge. It sits between the pad input and the byte-consuming logic (FIFO or command parser).

## Interface
- `SYSTEM_CLOCK_FREQ`, 100000000: clock frequency in Hz.
- `BAUD_RATE`, 115200: line bit rate in bit/s.
- Derived, not overridable: `DIVIDER = SYSTEM_CLOCK_FREQ / BAUD_RATE` (integer floor, 868 at defaults) and `HALF = DIVIDER / 2` (434).
- Legal range: 4 <= DIVIDER <= 65535.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `rx`  in  1  asynchronous serial line; idles high.
- `data`  out  8  received byte; stable while `valid` = 1.
- `valid`  out  1  `data` holds an unconsumed byte.
- `ready`  in  1  consumer accepts `data` when `valid && ready` at a rising edge.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a byte completed while the previous one was still held; the new byte is dropped.

## Operation
- Input sync: `rx` passes through two flip-flops to produce `rx_s`; both flops reset to 1. All decisions use `rx_s` only.
- Counter: 16-bit bit-timer `cnt` and 3-bit `bit_idx`. Both are cleared on every state entry that starts a timing interval.
- IDLE: `cnt` = 0. If `rx_s` = 0, go to START with `cnt` = 0.
- START: increment `cnt`. At `cnt` = HALF-1:
  - if `rx_s` = 0, go to DATA with `cnt` = 0 and `bit_idx` = 0;
  - if `rx_s` = 1, the start was a glitch: go to IDLE, no flags.
- DATA: increment `cnt`. At `cnt` = DIVIDER-1:
  - shift `rx_s` into the MSB of the 8-bit shift register (shift right, so the first bit ends up in bit 0);
  - set `cnt` = 0 and increment `bit_idx`;
  - after bit 7 is sampled, go to STOP.
- STOP: at `cnt` = DIVIDER-1, sample `rx_s`:
  - if 1: deliver the byte (delivery rules below), then go to IDLE;
  - if 0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s` = 1, then go to IDLE. This prevents a break condition from retriggering frames.
- Delivery on a good stop bit:
  - if `valid` = 0, or `ready` = 1 in the same cycle: load `data` from the shift register; `valid` = 1 on the next cycle.
  - otherwise: pulse `overrun`; `data` and `valid` are unchanged.
- Consumption: `valid && ready` with no simultaneous delivery clears `valid` on the next cycle.
- `data` never changes while `valid` = 1 except on a simultaneous accept-and-deliver.
- Reset (`reset_n` = 0 at an edge), including mid-frame:
  - state = IDLE; `cnt`, `bit_idx`, shift register, `data` = 0;
  - `valid`, `frame_err`, `overrun` = 0; sync flops = 1.
  - A frame in progress is lost. The receiver needs a fresh falling edge after reset releases.

## Timing
- Let t0 be the edge at which IDLE sees `rx_s` = 0. `rx_s` lags `rx` by 2 cycles.
- Start check: t0 + HALF.
- Data bit k (k = 0..7) sampled at t0 + HALF + (k+1)·DIVIDER.
- Stop bit sampled at t0 + HALF + 9·DIVIDER.
- `valid`, `frame_err`, or `overrun` asserts one cycle after the stop sample.
- Back-to-back frames: IDLE is re-entered at the stop sample, so a start edge arriving HALF cycles later is caught. No minimum inter-frame gap beyond the stop bit.
- `frame_err` and `overrun` are high for exactly one cycle and are mutually exclusive.
- `valid` may remain high indefinitely while `ready` = 0.

## Test plan
Bench uses SYSTEM_CLOCK_FREQ = 16, BAUD_RATE = 1 (DIVIDER = 16, HALF = 8), with `rx` driven 16 cycles per bit.
- Single frame 0xA5 with `ready` = 0 → `valid` rises exactly 2 + 8 + 9·16 + 1 cycles after the `rx` falling edge; `data` = 0xA5 is held; `ready` pulse → `valid` = 0 next cycle.
- Glitch: `rx` low for 4 cycles, then high → no `valid`, no `frame_err`; a following frame 0x3C is received correctly.
- Stop bit driven low on frame 0x55 → one-cycle `frame_err`, `valid` stays 0; `rx` held low 40 more cycles → no new frame until `rx` returns high.
- Frames 0x01 then 0x02 back-to-back with `ready` = 0 → `data` = 0x01, one `overrun` pulse at the second stop; with `ready` = 1 only at the second delivery cycle → `data` = 0x02, `valid` stays 1, no `overrun`.
- `reset_n` = 0 for 1 cycle at data bit 3 → `valid` = 0, no flags; the next full frame 0xFF is received correctly.
- Continuous stream 0x00..0x0F with `ready` = 1 → all 16 bytes delivered in order, no flags.
